// File: rtl/s32x_vdp_fill_copy_pkg.sv
// Shared types and register-select codes for the VDP auto-fill/copy engine.
package s32x_vdp_fill_copy_pkg;

    typedef enum logic [2:0] {
        FC_IDLE,
        FC_FILL,
        FC_CRD,
        FC_CWT,
        FC_CWR
    } FC_STATE_t;

    localparam logic [2:0] FC_SEL_LEN  = 3'd0;
    localparam logic [2:0] FC_SEL_DST  = 3'd1;
    localparam logic [2:0] FC_SEL_SRC  = 3'd2;
    localparam logic [2:0] FC_SEL_DATA = 3'd3;
    localparam logic [2:0] FC_SEL_COPY = 3'd4;

endpackage

// File: rtl/s32x_vdp_fill_copy_wrap_inc.sv
// Address incrementer whose carry stops at WRAP_W bits; upper bits pass through.
// WRAP_W must not exceed ADDR_W.
module s32x_wrap_inc #(
    parameter int ADDR_W = 16,
    parameter int WRAP_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_inc
);

    logic [WRAP_W-1:0] low_inc;

    assign low_inc = addr[WRAP_W-1:0] + WRAP_W'(1);

    generate
        if (WRAP_W >= ADDR_W) begin : g_full
            assign addr_inc = ADDR_W'(low_inc);
        end else begin : g_split
            assign addr_inc = {addr[ADDR_W-1:WRAP_W], low_inc};
        end
    endgenerate

endmodule

// File: rtl/s32x_vdp_fill_copy.sv
// Framebuffer auto-fill / block-copy engine, paced by the dot-clock enable and
// gated by the framebuffer grant.
module s32x_vdp_fill_copy
    import s32x_vdp_fill_copy_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic                CFG_WE,
    input  logic [2:0]          CFG_SEL,
    input  logic [ADDR_W-1:0]   CFG_D,
    input  logic                ABORT,
    output logic                BUSY,
    output logic [ADDR_W-1:0]   DST_Q,
    input  logic                FB_GNT,
    output logic [ADDR_W-1:0]   FB_A,
    output logic [DATA_W-1:0]   FB_D,
    output logic [DATA_W/8-1:0] FB_WE,
    input  logic [DATA_W-1:0]   FB_Q
);

    localparam int NLANES = DATA_W / 8;

    FC_STATE_t         state, state_next;
    logic [LEN_W-1:0]  len_r, cnt_r;
    logic [ADDR_W-1:0] dst_r, src_r, dst_inc, src_inc;
    logic [DATA_W-1:0] data_r, hold_r;
    logic [ADDR_W-1:0] fb_a_r, fb_a;
    logic [DATA_W-1:0] fb_d_r, fb_d;
    logic [NLANES-1:0] fb_we;
    logic              step;
    logic              last;

    s32x_wrap_inc #(.ADDR_W(ADDR_W), .WRAP_W(WRAP_W)) u_dst_inc (
        .addr     (dst_r),
        .addr_inc (dst_inc)
    );

    s32x_wrap_inc #(.ADDR_W(ADDR_W), .WRAP_W(WRAP_W)) u_src_inc (
        .addr     (src_r),
        .addr_inc (src_inc)
    );

    // A step only happens when paced, granted and not being cancelled.
    assign step = CE & FB_GNT & ~ABORT;
    assign last = (cnt_r == '0);

    always_comb begin
        state_next = state;
        fb_a       = fb_a_r;
        fb_d       = fb_d_r;
        fb_we      = '0;
        case (state)
            FC_IDLE: begin
                if (CFG_WE && !ABORT) begin
                    if (CFG_SEL == FC_SEL_DATA)      state_next = FC_FILL;
                    else if (CFG_SEL == FC_SEL_COPY) state_next = FC_CRD;
                end
            end
            FC_FILL: begin
                if (ABORT) begin
                    state_next = FC_IDLE;
                end else if (step) begin
                    fb_a  = dst_r;
                    fb_d  = data_r;
                    fb_we = '1;
                    if (last) state_next = FC_IDLE;
                end
            end
            FC_CRD: begin
                if (ABORT) begin
                    state_next = FC_IDLE;
                end else if (step) begin
                    fb_a       = src_r;
                    state_next = FC_CWT;
                end
            end
            FC_CWT: begin
                state_next = ABORT ? FC_IDLE : FC_CWR;
            end
            FC_CWR: begin
                if (ABORT) begin
                    state_next = FC_IDLE;
                end else if (step) begin
                    fb_a       = dst_r;
                    fb_d       = hold_r;
                    fb_we      = '1;
                    state_next = last ? FC_IDLE : FC_CRD;
                end
            end
            default: state_next = FC_IDLE;
        endcase
    end

    // FB_A/FB_D are remembered so they hold their last driven value between steps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= FC_IDLE;
            len_r  <= '0;
            cnt_r  <= '0;
            dst_r  <= '0;
            src_r  <= '0;
            data_r <= '0;
            hold_r <= '0;
            fb_a_r <= '0;
            fb_d_r <= '0;
        end else begin
            state  <= state_next;
            fb_a_r <= fb_a;
            fb_d_r <= fb_d;
            case (state)
                FC_IDLE: begin
                    if (CFG_WE) begin
                        case (CFG_SEL)
                            FC_SEL_LEN: len_r <= LEN_W'(CFG_D);
                            FC_SEL_DST: dst_r <= CFG_D;
                            FC_SEL_SRC: src_r <= CFG_D;
                            FC_SEL_DATA: begin
                                data_r <= DATA_W'(CFG_D);
                                cnt_r  <= len_r;
                            end
                            FC_SEL_COPY: cnt_r <= len_r;
                            default: ;
                        endcase
                    end
                end
                FC_FILL: begin
                    if (step) begin
                        dst_r <= dst_inc;
                        cnt_r <= cnt_r - LEN_W'(1);
                    end
                end
                FC_CWT: hold_r <= FB_Q;
                FC_CWR: begin
                    if (step) begin
                        dst_r <= dst_inc;
                        src_r <= src_inc;
                        cnt_r <= cnt_r - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY  = (state != FC_IDLE);
    assign DST_Q = dst_r;
    assign FB_A  = fb_a;
    assign FB_D  = fb_d;
    assign FB_WE = fb_we;

endmodule

// File: tb/tb_s32x_vdp_fill_copy.sv
// Self-checking bench: directed fill/copy/stall/abort/reset cases plus randomized runs
// checked against a word-list reference model and a bench-side framebuffer RAM.
module tb_s32x_vdp_fill_copy;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [2:0]  CFG_SEL = 3'd0;
    logic [15:0] CFG_D = 16'h0;
    logic        ABORT = 1'b0;
    logic        BUSY;
    logic [15:0] DST_Q;
    logic        FB_GNT = 1'b0;
    logic [15:0] FB_A;
    logic [15:0] FB_D;
    logic [1:0]  FB_WE;
    logic [15:0] FB_Q;

    s32x_vdp_fill_copy dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CE     (CE),
        .CFG_WE (CFG_WE),
        .CFG_SEL(CFG_SEL),
        .CFG_D  (CFG_D),
        .ABORT  (ABORT),
        .BUSY   (BUSY),
        .DST_Q  (DST_Q),
        .FB_GNT (FB_GNT),
        .FB_A   (FB_A),
        .FB_D   (FB_D),
        .FB_WE  (FB_WE),
        .FB_Q   (FB_Q)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;
    int          cyc = 0;
    int          ce_mode = 0;
    int          gnt_pct = 100;
    int          gnt_hold = 0;
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    wr_t         exp_q[$];
    logic [7:0]  m_len = 8'h0;
    logic [15:0] m_dst = 16'h0, m_src = 16'h0, m_data = 16'h0;
    logic [15:0] run_dst0, run_src0;
    logic        run_copy = 1'b0;
    logic        model_busy = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] winc(input logic [15:0] a, input int n);
        logic [7:0] lo;
        lo = a[7:0] + 8'(n);
        return {a[15:8], lo};
    endfunction

    // Framebuffer RAM: byte-lane writes, registered read.
    always @(posedge CLK) begin
        if (FB_WE[0]) mem[FB_A][7:0]  <= FB_D[7:0];
        if (FB_WE[1]) mem[FB_A][15:8] <= FB_D[15:8];
        FB_Q <= mem[FB_A];
    end

    // Write monitor, sampled mid-cycle where inputs and outputs are settled.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (!FB_GNT) checkOutput("we_while_ungranted", 32'(FB_WE), 32'h0);
            if (FB_WE != 2'b00) begin
                wr_t e;
                checkOutput("we_lanes", 32'(FB_WE), 32'h3);
                checkOutput("write_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(FB_A), 32'(e.a));
                    checkOutput("wr_data", 32'(FB_D), 32'(e.d));
                    ref_mem[e.a] = e.d;
                end
                wr_count++;
            end
        end
    end

    task automatic step_clk();
        @(posedge CLK);
        #1;
        cyc++;
        case (ce_mode)
            0:       CE = 1'b1;
            1:       CE = cyc[0];
            default: CE = 1'($urandom_range(0, 1));
        endcase
        if (gnt_hold > 0) begin
            FB_GNT = 1'b0;
            if (CE) gnt_hold--;
        end else begin
            FB_GNT = ($urandom_range(0, 99) < gnt_pct);
        end
    endtask

    // Build the expected word list for a run straight from the register values.
    task automatic plan_run(input logic copy);
        logic [15:0] ov [logic [15:0]];
        logic [15:0] ad, as, v;
        for (int i = 0; i <= int'(m_len); i++) begin
            ad = winc(m_dst, i);
            if (copy) begin
                as = winc(m_src, i);
                v  = ov.exists(as) ? ov[as] : ref_mem[as];
            end else begin
                v = m_data;
            end
            ov[ad] = v;
            exp_q.push_back('{a: ad, d: v});
        end
        run_dst0   = m_dst;
        run_src0   = m_src;
        run_copy   = copy;
        m_dst      = winc(m_dst, int'(m_len) + 1);
        if (copy) m_src = winc(m_src, int'(m_len) + 1);
        model_busy = 1'b1;
        wr_count   = 0;
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] d);
        logic started;
        started = 1'b0;
        if (!model_busy) begin
            case (sel)
                3'd0: m_len = d[7:0];
                3'd1: m_dst = d;
                3'd2: m_src = d;
                3'd3: begin m_data = d; plan_run(1'b0); started = 1'b1; end
                3'd4: begin plan_run(1'b1); started = 1'b1; end
                default: ;
            endcase
        end
        CFG_SEL = sel;
        CFG_D   = d;
        CFG_WE  = 1'b1;
        step_clk();
        CFG_WE  = 1'b0;
        if (started) checkOutput("busy_rise", 32'(BUSY), 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 6000) begin
            step_clk();
            n++;
        end
        checkOutput({tag, "_done"}, 32'(BUSY), 32'h0);
        checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
        checkOutput({tag, "_dst_q"}, 32'(DST_Q), 32'(m_dst));
        exp_q.delete();
        model_busy = 1'b0;
    endtask

    task automatic abort_after(input string tag, input int k);
        int n;
        n = 0;
        while (wr_count < k && n < 6000) begin
            step_clk();
            n++;
        end
        checkOutput({tag, "_reach"}, 32'(wr_count), 32'(k));
        ABORT = 1'b1;
        step_clk();
        ABORT = 1'b0;
        m_dst = winc(run_dst0, wr_count);
        if (run_copy) m_src = winc(run_src0, wr_count);
        exp_q.delete();
        model_busy = 1'b0;
        checkOutput({tag, "_busy"}, 32'(BUSY), 32'h0);
        checkOutput({tag, "_dst_q"}, 32'(DST_Q), 32'(m_dst));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, bad, len, k;
        logic [15:0] base;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        #3;
        checkOutput("rst_busy", 32'(BUSY), 32'h0);
        checkOutput("rst_we", 32'(FB_WE), 32'h0);
        checkOutput("rst_fb_a", 32'(FB_A), 32'h0);
        checkOutput("rst_fb_d", 32'(FB_D), 32'h0);
        checkOutput("rst_dst_q", 32'(DST_Q), 32'h0);
        step_clk();
        step_clk();
        RST_N = 1'b1;
        step_clk();

        // 1: basic fill, CE every other clock
        ce_mode = 1; gnt_pct = 100;
        applyStimulus(3'd0, 16'd3);
        applyStimulus(3'd1, 16'h1234);
        applyStimulus(3'd3, 16'hABCD);
        wait_idle("fill");
        checkOutput("fill_dst_val", 32'(DST_Q), 32'h1238);

        // 2: low-byte wrap
        applyStimulus(3'd1, 16'h12FE);
        applyStimulus(3'd3, 16'h5A5A);
        wait_idle("wrap");
        checkOutput("wrap_dst_val", 32'(DST_Q), 32'h1202);

        // 3: copy
        ce_mode = 0;
        for (int i = 0; i < 3; i++) begin
            mem[16'h0100 + i]     = 16'(i + 1);
            ref_mem[16'h0100 + i] = 16'(i + 1);
        end
        applyStimulus(3'd2, 16'h0100);
        applyStimulus(3'd1, 16'h0200);
        applyStimulus(3'd0, 16'd2);
        applyStimulus(3'd4, 16'h0000);
        wait_idle("copy");
        checkOutput("copy_dst_val", 32'(DST_Q), 32'h0203);
        step_clk();
        for (int i = 0; i < 3; i++) checkOutput("copy_ram", 32'(mem[16'h0200 + i]), 32'(i + 1));

        // 4: grant stall after the first write
        applyStimulus(3'd0, 16'd1);
        applyStimulus(3'd1, 16'h3300);
        applyStimulus(3'd3, 16'h0F0F);
        n = 0;
        while (wr_count < 1 && n < 100) begin step_clk(); n++; end
        FB_GNT = 1'b0; gnt_hold = 10;
        n = 0;
        while (gnt_hold > 0 && n < 200) begin step_clk(); n++; end
        checkOutput("stall_writes", 32'(wr_count), 32'h1);
        wait_idle("stall");

        // 5: abort a long fill, with an ignored DST write mid-run
        applyStimulus(3'd0, 16'd255);
        applyStimulus(3'd1, 16'h44F0);
        applyStimulus(3'd3, 16'hC3C3);
        n = 0;
        while (wr_count < 2 && n < 100) begin step_clk(); n++; end
        applyStimulus(3'd1, 16'h5555);
        abort_after("abort", 5);
        checkOutput("abort_dst_val", 32'(DST_Q), 32'h44F5);

        // 6: reset while the copy waits for read data
        applyStimulus(3'd2, 16'h0600);
        applyStimulus(3'd1, 16'h0700);
        applyStimulus(3'd0, 16'd3);
        applyStimulus(3'd4, 16'h0000);
        step_clk();
        RST_N = 1'b0;
        #1;
        checkOutput("rst6_busy", 32'(BUSY), 32'h0);
        checkOutput("rst6_we", 32'(FB_WE), 32'h0);
        checkOutput("rst6_dst_q", 32'(DST_Q), 32'h0);
        checkOutput("rst6_fb_a", 32'(FB_A), 32'h0);
        exp_q.delete();
        model_busy = 1'b0;
        m_len = 8'h0; m_dst = 16'h0; m_src = 16'h0; m_data = 16'h0;
        step_clk();
        RST_N = 1'b1;
        step_clk();
        applyStimulus(3'd3, 16'h0077);
        wait_idle("post_rst");

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            ce_mode = $urandom_range(0, 2);
            gnt_pct = $urandom_range(40, 100);
            len = ($urandom_range(0, 11) == 0) ? 255 : $urandom_range(0, 20);
            base = 16'($urandom);
            if ($urandom_range(0, 1) == 1) base[7:0] = 8'(250 + $urandom_range(0, 5));
            applyStimulus(3'd0, 16'(len));
            applyStimulus(3'd1, base);
            applyStimulus(3'd2, 16'($urandom));
            if ($urandom_range(0, 1) == 1) applyStimulus(3'd3, 16'($urandom));
            else applyStimulus(3'd4, 16'($urandom));
            if ($urandom_range(0, 2) == 0) applyStimulus(3'($urandom_range(0, 4)), 16'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, len);
                abort_after("rnd_abort", k);
            end else begin
                wait_idle("rnd");
            end
        end

        step_clk();
        step_clk();
        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
        checkOutput("ram_sweep", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
